spawnout_queue_reader: RTL and testbench
========================================

// Module: spawnout_queue_reader
// PURPOSE
//  Consumer end of the spawn-out queue. Polls the 64-bit BRAM ring that the scheduler's spawn-out writer fills,
//  detects a valid task entry, streams all its words on an AXI-Stream master (header first), then clears the
//  header valid bit and advances the read pointer so the slot space is returned to the writer.
// PARAMETERS
//  QUEUE_LEN      1024  queue depth in 64-bit words (power of two)
//  POLL_INTERVAL  16    idle cycles between header polls when the header word is not valid (>=1)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-high
//  queue_addr          out  32  BRAM byte address (word index << 3)
//  queue_en            out  1   BRAM enable
//  queue_we            out  8   BRAM byte write enables
//  queue_din           out  64  BRAM write data
//  queue_dout          in   64  BRAM read data, valid 1 cycle after en with we==0
//  outStream_TDATA     out  64  task word
//  outStream_TVALID    out  1   word valid
//  outStream_TREADY    in   1   downstream ready
//  outStream_TLAST     out  1   last word of entry
//  rd_idx              out  $clog2(QUEUE_LEN)  current entry start index (words)
//  freed_words_valid   out  1   1-cycle pulse: entry released
//  freed_words         out  11  words released with that pulse
// BEHAVIOUR
//  Entry layout (word offsets from rd_idx, modulo QUEUE_LEN): 0 header {valid[63], #cops[31:24], #deps[23:16],
//   #args[15:8]}; 1 taskID; 2 pTaskID; 3 {arch[33:32], type[31:0]}; then args, deps (1 word each), copies
//   (3 words each). len = 4 + args + deps + 3*cops, computed in 11 bits, no overflow for 8-bit counts.
//  Reset: all outputs 0, rd_idx=0, state IDLE, poll counter 0; any in-flight entry is abandoned, header untouched.
//  FSM: IDLE -> issue read of header (en=1, we=0) -> HDR_WAIT (1 cyc) -> HDR_CHECK: valid=0 -> POLL
//   (wait POLL_INTERVAL cycles) -> IDLE; valid=1 -> latch counts, len, word_cnt=0, present header on stream -> SEND.
//  SEND: TVALID held with stable TDATA/TLAST until TVALID&TREADY; then word_cnt++; if word_cnt==len-1 -> CLEAR,
//   else READ (en=1, addr=(rd_idx+word_cnt) mod QUEUE_LEN) -> WAIT (1 cyc) -> SEND with queue_dout captured.
//   TLAST=1 only on word len-1. Throughput: 1 word per 3 cycles max; no read-ahead.
//  CLEAR: en=1, we=8'h80, din=0, addr=rd_idx<<3 (zeroes byte 7 -> valid bit). Then ADVANCE: rd_idx=(rd_idx+len)
//   mod QUEUE_LEN, freed_words_valid=1, freed_words=len, -> IDLE. Payload words are not cleared.
//  Wrap-around: every address computed mod QUEUE_LEN; an entry straddling the top continues at word 0.
//  queue_en=0 and queue_we=0 in every state not listed as accessing BRAM.
//  TREADY low indefinitely: block stalls in SEND, no BRAM traffic. TREADY high before TVALID: ignored.
// CONFIGURATION
//  SPAWNOUT_READER_STATS_EN defined: extra outputs tasks_read[31:0] (increments at ADVANCE, wraps) and
//   stall_cycles[31:0] (increments each SEND cycle with TVALID&!TREADY, saturates); both cleared by rst.
//  Undefined: ports absent, no counters synthesised.
// STRUCTURE
//  Shared package: header field bit positions, SPAWNOUT_VALID_BIT=63, entry fixed length 4, words-per-copy 3,
//   state enum. Entry length/count fields as typedefs shared with the spawn-out writer.
//  Single module; no sub-module (optional: spawnout_hdr_decode function in package, not a module).
// TESTING
//  1 Header 0x8000000000000000 at 0, taskID 0x1234567887654321, pTaskID 0x8765432112345678, word3
//    0x0000000311223344, TREADY=1 -> 4 beats in that order, TLAST on 4th, header write we=0x80 addr 0,
//    freed_words=4, rd_idx=4.
//  2 Header valid=0 -> no stream beats, header re-read every POLL_INTERVAL+3 cycles, rd_idx stays 0.
//  3 Entry args=2 deps=1 cops=1 at rd_idx=0 -> 10 beats, TLAST on beat 10, rd_idx=10, freed_words=10.
//  4 rd_idx=QUEUE_LEN-2 with 4-word entry -> reads addr 0x1FF0,0x1FF8,0x0,0x8; rd_idx=2 afterwards.
//  5 TREADY low 20 cycles on beat 2 -> TDATA/TVALID stable for all 20 cycles, no queue_en, then completes.
//  6 rst asserted mid-SEND -> next cycle TVALID=0, queue_en=0, rd_idx=0; header at 0 still valid, re-streamed.

Source files
------------

// File: rtl/spawnout_queue_reader_pkg.sv
// Shared definitions for the spawn-out queue consumer.
// Also covers header field positions, entry sizing types and the reader state encoding.
package spawnout_queue_reader_pkg;

    localparam int SPAWNOUT_VALID_BIT  = 63;
    localparam int SPAWNOUT_COPS_MSB   = 31;
    localparam int SPAWNOUT_COPS_LSB   = 24;
    localparam int SPAWNOUT_DEPS_MSB   = 23;
    localparam int SPAWNOUT_DEPS_LSB   = 16;
    localparam int SPAWNOUT_ARGS_MSB   = 15;
    localparam int SPAWNOUT_ARGS_LSB   = 8;
    localparam int SPAWNOUT_FIXED_LEN  = 4;
    localparam int SPAWNOUT_COPY_WORDS = 3;
    localparam int SPAWNOUT_LEN_W      = 11;

    // Sizing types shared with the spawn-out writer
    typedef logic [7:0]                spawnout_count_t;
    typedef logic [SPAWNOUT_LEN_W-1:0] spawnout_len_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_WAIT,
        ST_HDR_CHECK,
        ST_POLL,
        ST_SEND,
        ST_READ,
        ST_WAIT,
        ST_CLEAR,
        ST_ADVANCE
    } spawnout_state_t;

    function automatic logic spawnout_hdr_valid(input logic [63:0] hdr);
        return hdr[SPAWNOUT_VALID_BIT];
    endfunction

    // Total entry length in words; 8-bit counts cannot overflow 11 bits
    function automatic spawnout_len_t spawnout_entry_len(input logic [63:0] hdr);
        spawnout_count_t cops;
        spawnout_count_t deps;
        spawnout_count_t args;
        cops = hdr[SPAWNOUT_COPS_MSB:SPAWNOUT_COPS_LSB];
        deps = hdr[SPAWNOUT_DEPS_MSB:SPAWNOUT_DEPS_LSB];
        args = hdr[SPAWNOUT_ARGS_MSB:SPAWNOUT_ARGS_LSB];
        return SPAWNOUT_LEN_W'(SPAWNOUT_FIXED_LEN)
             + spawnout_len_t'(args)
             + spawnout_len_t'(deps)
             + spawnout_len_t'(cops) * SPAWNOUT_LEN_W'(SPAWNOUT_COPY_WORDS);
    endfunction

endpackage

// File: rtl/spawnout_queue_reader_if.sv
// BRAM port and AXI-Stream task output of the spawn-out queue reader.
// The reader owns the master side; BRAM and stream sink sit on the slave side.
interface spawnout_queue_reader_if;

    logic [31:0] queue_addr;
    logic        queue_en;
    logic [7:0]  queue_we;
    logic [63:0] queue_din;
    logic [63:0] queue_dout;

    logic [63:0] outStream_TDATA;
    logic        outStream_TVALID;
    logic        outStream_TREADY;
    logic        outStream_TLAST;

    modport master (
        output queue_addr, queue_en, queue_we, queue_din,
        input  queue_dout,
        output outStream_TDATA, outStream_TVALID, outStream_TLAST,
        input  outStream_TREADY
    );

    modport slave (
        input  queue_addr, queue_en, queue_we, queue_din,
        output queue_dout,
        input  outStream_TDATA, outStream_TVALID, outStream_TLAST,
        output outStream_TREADY
    );

endinterface

// File: rtl/spawnout_queue_reader.sv
// Spawn-out queue consumer: polls the BRAM ring, streams each valid entry, clears its header, frees the slots.
// Optional SPAWNOUT_READER_STATS_EN adds tasks_read / stall_cycles counters.
module spawnout_queue_reader
    import spawnout_queue_reader_pkg::*;
#(
    parameter int QUEUE_LEN     = 1024,
    parameter int POLL_INTERVAL = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    spawnout_queue_reader_if.master      bus,
    output logic [$clog2(QUEUE_LEN)-1:0] rd_idx,
    output logic                         freed_words_valid,
    output logic [SPAWNOUT_LEN_W-1:0]    freed_words
`ifdef SPAWNOUT_READER_STATS_EN
    ,
    output logic [31:0]                  tasks_read,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int AW = $clog2(QUEUE_LEN);
    localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    spawnout_state_t r_state;
    spawnout_state_t w_state_next;
    logic [AW-1:0]   r_rd_idx;
    spawnout_len_t   r_word_cnt;
    spawnout_len_t   r_len;
    logic [63:0]     r_data;
    logic [PW-1:0]   r_poll_cnt;

    logic            w_en;
    logic [7:0]      w_we;
    logic [AW-1:0]   w_addr_word;
    logic            w_tvalid;
    logic            w_tlast;
    logic            w_freed;
    logic            w_poll_done;
    logic            w_hdr_valid;
    spawnout_len_t   w_hdr_len;

    assign w_hdr_valid = spawnout_hdr_valid(r_data);
    assign w_hdr_len   = spawnout_entry_len(r_data);
    assign w_poll_done = (r_poll_cnt == PW'(POLL_INTERVAL - 1));

    always_comb begin
        w_state_next = r_state;
        w_en         = 1'b0;
        w_we         = 8'h00;
        w_addr_word  = r_rd_idx;
        w_tvalid     = 1'b0;
        w_tlast      = 1'b0;
        w_freed      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_en         = 1'b1;
                w_state_next = ST_HDR_WAIT;
            end
            ST_HDR_WAIT:  w_state_next = ST_HDR_CHECK;
            ST_HDR_CHECK: w_state_next = w_hdr_valid ? ST_SEND : ST_POLL;
            ST_POLL: begin
                if (w_poll_done) w_state_next = ST_IDLE;
            end
            ST_SEND: begin
                w_tvalid = 1'b1;
                w_tlast  = (r_word_cnt == r_len - SPAWNOUT_LEN_W'(1));
                if (bus.outStream_TREADY) w_state_next = w_tlast ? ST_CLEAR : ST_READ;
            end
            ST_READ: begin
                // Power-of-two depth: truncating the sum wraps past the top of the ring
                w_en         = 1'b1;
                w_addr_word  = r_rd_idx + AW'(r_word_cnt);
                w_state_next = ST_WAIT;
            end
            ST_WAIT: w_state_next = ST_SEND;
            ST_CLEAR: begin
                w_en         = 1'b1;
                w_we         = 8'h80;
                w_state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                w_freed      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_idx   <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_poll_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_HDR_WAIT, ST_WAIT: r_data <= bus.queue_dout;
                ST_HDR_CHECK: begin
                    if (w_hdr_valid) begin
                        r_len      <= w_hdr_len;
                        r_word_cnt <= '0;
                    end
                end
                ST_POLL: r_poll_cnt <= w_poll_done ? '0 : r_poll_cnt + PW'(1);
                ST_SEND: begin
                    if (bus.outStream_TREADY && !w_tlast) r_word_cnt <= r_word_cnt + SPAWNOUT_LEN_W'(1);
                end
                ST_ADVANCE: r_rd_idx <= r_rd_idx + AW'(r_len);
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet for as long as reset is held
    assign bus.queue_en         = w_en && !rst;
    assign bus.queue_we         = rst ? 8'h00 : w_we;
    assign bus.queue_addr       = bus.queue_en ? (32'(w_addr_word) << 3) : 32'd0;
    assign bus.queue_din        = 64'd0;
    assign bus.outStream_TVALID = w_tvalid && !rst;
    assign bus.outStream_TDATA  = bus.outStream_TVALID ? r_data : 64'd0;
    assign bus.outStream_TLAST  = w_tlast && !rst;
    assign rd_idx               = r_rd_idx;
    assign freed_words_valid    = w_freed && !rst;
    assign freed_words          = freed_words_valid ? r_len : '0;

`ifdef SPAWNOUT_READER_STATS_EN
    logic [31:0] r_tasks_read;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tasks_read   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_state == ST_ADVANCE) r_tasks_read <= r_tasks_read + 32'd1;
            if (r_state == ST_SEND && !bus.outStream_TREADY && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign tasks_read   = r_tasks_read;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_spawnout_queue_reader.sv
// Directed bench for spawnout_queue_reader: BRAM model, entry-level scoreboard and literal spot checks.
module tb_spawnout_queue_reader;

    localparam int QL = 1024;
    localparam int PI = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spawnout_queue_reader_if q_if ();
    logic [9:0]  rd_idx;
    logic        freed_words_valid;
    logic [10:0] freed_words;
`ifdef SPAWNOUT_READER_STATS_EN
    logic [31:0] tasks_read;
    logic [31:0] stall_cycles;
`endif

    spawnout_queue_reader #(.QUEUE_LEN(QL), .POLL_INTERVAL(PI)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (q_if),
        .rd_idx            (rd_idx),
        .freed_words_valid (freed_words_valid),
        .freed_words       (freed_words)
`ifdef SPAWNOUT_READER_STATS_EN
        ,
        .tasks_read        (tasks_read),
        .stall_cycles      (stall_cycles)
`endif
    );

    // BRAM with one-cycle registered read
    logic [63:0] mem [QL];
    always @(posedge clk) begin
        if (q_if.queue_en) begin
            if (q_if.queue_we != 8'h00) begin
                for (int b = 0; b < 8; b++)
                    if (q_if.queue_we[b]) mem[q_if.queue_addr[12:3]][b*8 +: 8] = q_if.queue_din[b*8 +: 8];
            end else begin
                q_if.queue_dout <= mem[q_if.queue_addr[12:3]];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within budget, required event", name);
    endtask

    function automatic int entry_len(input logic [63:0] h);
        return 4 + int'(h[15:8]) + int'(h[23:16]) + 3 * int'(h[31:24]);
    endfunction

    // Scoreboard: expected beats per entry, released lengths, model read pointer
    logic [63:0] exp_data [$];
    bit          exp_last [$];
    int          exp_len  [$];
    int          model_idx = 0;
    logic [63:0] beat_log [$];
    bit          tlast_log [$];
    int          rd_cyc [$];
    logic [31:0] rd_addr [$];
    int          releases = 0;
    int          last_freed = 0;
    int          cyc = 0;
    bit          adv_pending = 0;
    bit          stall_prev = 0;
    logic [63:0] stall_data = '0;

    task automatic expect_entry(input int idx);
        int len;
        len = entry_len(mem[idx]);
        for (int k = 0; k < len; k++) begin
            exp_data.push_back(mem[(idx + k) % QL]);
            exp_last.push_back(k == len - 1);
        end
        exp_len.push_back(len);
    endtask

    task automatic load_entry(input int idx, input int args, input int deps, input int cops, input int tag);
        logic [63:0] h;
        int          len;
        h = {1'b1, 31'd0, 8'(cops), 8'(deps), 8'(args), 8'h00};
        mem[idx] = h;
        len = entry_len(h);
        for (int k = 1; k < len; k++) mem[(idx + k) % QL] = {32'(tag), 32'(k)};
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_data.delete();
            exp_last.delete();
            exp_len.delete();
            model_idx   = 0;
            adv_pending = 0;
            stall_prev  = 0;
        end else begin
            if (adv_pending) begin
                check("rd_idx_after_release", 64'(rd_idx), 64'(model_idx));
                adv_pending = 0;
            end
            if (stall_prev) begin
                check("stall_tvalid_held", 64'(q_if.outStream_TVALID), 64'd1);
                check("stall_tdata_stable", q_if.outStream_TDATA, stall_data);
            end
            if (q_if.outStream_TVALID && !q_if.outStream_TREADY) begin
                check("no_bram_in_stall", 64'(q_if.queue_en), 64'd0);
                stall_prev = 1;
                stall_data = q_if.outStream_TDATA;
            end else begin
                stall_prev = 0;
            end
            if (q_if.outStream_TVALID && q_if.outStream_TREADY) begin
                beat_log.push_back(q_if.outStream_TDATA);
                tlast_log.push_back(q_if.outStream_TLAST);
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got TDATA=0x%0h, required no beat", q_if.outStream_TDATA);
                end else begin
                    check("beat_tdata", q_if.outStream_TDATA, exp_data.pop_front());
                    check("beat_tlast", 64'(q_if.outStream_TLAST), 64'(exp_last.pop_front()));
                end
            end
            if (q_if.queue_en && q_if.queue_we != 8'h00) begin
                check("clear_we", 64'(q_if.queue_we), 64'h80);
                check("clear_addr", 64'(q_if.queue_addr), 64'(model_idx * 8));
                check("clear_din", q_if.queue_din, 64'd0);
            end
            if (q_if.queue_en && q_if.queue_we == 8'h00) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(q_if.queue_addr);
            end
            if (freed_words_valid) begin
                last_freed = int'(freed_words);
                releases++;
                if (exp_len.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release: got freed_words=%0d, required no release", freed_words);
                end else begin
                    int len;
                    len = exp_len.pop_front();
                    check("freed_words", 64'(freed_words), 64'(len));
                    model_idx   = (model_idx + len) % QL;
                    adv_pending = 1;
                end
            end
        end
    end

    task automatic wait_release(input string name, input int budget);
        int start;
        int n;
        start = releases;
        n = 0;
        while (releases == start && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (releases == start) fail_event(name);
    endtask

    task automatic wait_tvalid(input string name, input int budget);
        int n;
        n = 0;
        while (!q_if.outStream_TVALID && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!q_if.outStream_TVALID) fail_event(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        beat_log.delete();
        tlast_log.delete();
    endtask

    initial begin
        int ok;
        int hi;
        for (int i = 0; i < QL; i++) mem[i] = 64'd0;
        q_if.outStream_TREADY = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", 64'(q_if.outStream_TVALID), 64'd0);
        check("reset_queue_en", 64'(q_if.queue_en), 64'd0);
        check("reset_queue_we", 64'(q_if.queue_we), 64'd0);
        check("reset_rd_idx", 64'(rd_idx), 64'd0);
        check("reset_freed_valid", 64'(freed_words_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_cyc.delete();
        rd_addr.delete();
        q_if.outStream_TREADY = 1'b1;

        // Empty queue: header polled every POLL_INTERVAL+3 cycles
        repeat (100) @(posedge clk);
        #1;
        check("poll_reads_seen", 64'(rd_cyc.size() >= 4), 64'd1);
        for (int i = 1; i < rd_cyc.size(); i++) check("poll_period", 64'(rd_cyc[i] - rd_cyc[i-1]), 64'd19);
        for (int i = 0; i < rd_addr.size(); i++) check("poll_addr", 64'(rd_addr[i]), 64'd0);
        check("poll_no_beats", 64'(beat_log.size()), 64'd0);
        check("poll_rd_idx", 64'(rd_idx), 64'd0);

        // Minimal 4-word entry
        mem[0] = 64'h8000000000000000;
        mem[1] = 64'h1234567887654321;
        mem[2] = 64'h8765432112345678;
        mem[3] = 64'h0000000311223344;
        expect_entry(0);
        wait_release("t1_release", 300);
        repeat (2) @(posedge clk);
        #1;
        check("t1_beats", 64'(beat_log.size()), 64'd4);
        if (beat_log.size() == 4) begin
            check("t1_beat0", beat_log[0], 64'h8000000000000000);
            check("t1_beat1", beat_log[1], 64'h1234567887654321);
            check("t1_beat2", beat_log[2], 64'h8765432112345678);
            check("t1_beat3", beat_log[3], 64'h0000000311223344);
            check("t1_tlast3", 64'(tlast_log[3]), 64'd1);
            check("t1_tlast2", 64'(tlast_log[2]), 64'd0);
        end
        check("t1_freed", 64'(last_freed), 64'd4);
        check("t1_rd_idx", 64'(rd_idx), 64'd4);
        check("t1_hdr_cleared", mem[0], 64'd0);

        // args=2 deps=1 cops=1 at index 0 after reset
        do_reset();
        load_entry(0, 2, 1, 1, 32'h1000);
        expect_entry(0);
        wait_release("t3_release", 300);
        repeat (2) @(posedge clk);
        #1;
        check("t3_beats", 64'(beat_log.size()), 64'd10);
        if (beat_log.size() == 10) begin
            check("t3_header", beat_log[0], 64'h8000000001010200);
            check("t3_tlast9", 64'(tlast_log[9]), 64'd1);
            check("t3_tlast8", 64'(tlast_log[8]), 64'd0);
        end
        check("t3_freed", 64'(last_freed), 64'd10);
        check("t3_rd_idx", 64'(rd_idx), 64'd10);

        // Backpressure on beat 2 for 20 cycles
        q_if.outStream_TREADY = 1'b0;
        load_entry(10, 0, 0, 0, 32'h5000);
        expect_entry(10);
        wait_tvalid("t5_beat1", 200);
        q_if.outStream_TREADY = 1'b1;
        @(posedge clk); #1;
        q_if.outStream_TREADY = 1'b0;
        wait_tvalid("t5_beat2", 50);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (q_if.outStream_TVALID && !q_if.queue_en && q_if.outStream_TDATA == mem[11]) ok++;
            @(posedge clk); #1;
        end
        check("t5_stall_cycles_stable", 64'(ok), 64'd20);
        q_if.outStream_TREADY = 1'b1;
        wait_release("t5_release", 300);
        repeat (2) @(posedge clk);
        #1;
        check("t5_rd_idx", 64'(rd_idx), 64'd14);

        // Large filler entry (len 1008) brings rd_idx to QUEUE_LEN-2
        load_entry(14, 254, 255, 165, 32'h7000);
        expect_entry(14);
        wait_release("filler_release", 5000);
        repeat (2) @(posedge clk);
        #1;
        check("filler_freed", 64'(last_freed), 64'd1008);
        check("filler_rd_idx", 64'(rd_idx), 64'd1022);

        // Entry straddling the top of the ring
        rd_addr.delete();
        rd_cyc.delete();
        load_entry(1022, 0, 0, 0, 32'h4000);
        expect_entry(1022);
        wait_release("t4_release", 300);
        hi = -1;
        for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] == 32'h1FF0) hi = i;
        check("t4_hdr_read_seen", 64'(hi >= 0 && hi + 3 < rd_addr.size()), 64'd1);
        if (hi >= 0 && hi + 3 < rd_addr.size()) begin
            check("t4_addr1", 64'(rd_addr[hi+1]), 64'h1FF8);
            check("t4_addr2", 64'(rd_addr[hi+2]), 64'h0);
            check("t4_addr3", 64'(rd_addr[hi+3]), 64'h8);
        end
        repeat (2) @(posedge clk);
        #1;
        check("t4_rd_idx", 64'(rd_idx), 64'd2);
        check("t4_hdr_cleared", 64'(mem[1022][63]), 64'd0);

        // Reset in the middle of SEND
        do_reset();
        q_if.outStream_TREADY = 1'b0;
        load_entry(0, 0, 0, 0, 32'h6000);
        expect_entry(0);
        wait_tvalid("t6_beat1", 200);
        q_if.outStream_TREADY = 1'b1;
        @(posedge clk); #1;
        q_if.outStream_TREADY = 1'b0;
        wait_tvalid("t6_beat2", 50);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_tvalid", 64'(q_if.outStream_TVALID), 64'd0);
        check("t6_queue_en", 64'(q_if.queue_en), 64'd0);
        check("t6_rd_idx", 64'(rd_idx), 64'd0);
        check("t6_hdr_kept", 64'(mem[0][63]), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        beat_log.delete();
        tlast_log.delete();
        q_if.outStream_TREADY = 1'b1;
        expect_entry(0);
        wait_release("t6_release", 300);
        repeat (2) @(posedge clk);
        #1;
        check("t6_restream_beats", 64'(beat_log.size()), 64'd4);
        check("t6_rd_idx_after", 64'(rd_idx), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
